// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV64 subset: R-type, addi, ld, sd, beq.
// Optional performance counters are built when MCFSM_PERF_CNT_EN is defined.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [3:0]       dbg_state
);

  // Memory handshake: mem_req is held high for the whole access; the access
  // completes in the cycle where mem_req=1 and mem_ready=1. mem_ready while
  // mem_req=0 carries no meaning and is ignored.

  localparam logic [3:0] S_RESET    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_ALU   = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam int          WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit          TO_EN  = (MEM_TIMEOUT > 0);
  localparam logic [31:0] TO_LIM = 32'(MEM_TIMEOUT);

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic              retire;
  logic [31:0]       wait_next;
  logic              timeout_hit;

  // The limit is reached when this stalled cycle would bring the count to MEM_TIMEOUT.
  assign wait_next   = 32'(wait_q) + 32'd1;
  assign timeout_hit = TO_EN && (wait_next >= TO_LIM);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else if (TO_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_LD, OP_SD: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: begin
        state_d = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
        wait_d  = '0;
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else if (TO_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          wait_d  = '0;
          retire  = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else if (TO_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: begin
        state_d = S_FETCH;
        wait_d  = '0;
        retire  = 1'b1;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      wait_q  <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  // Moore decode; the fetch write enables follow mem_ready so the PC/IR load
  // exactly once, and the branch PC write follows the ALU zero flag.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_FUNCT;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_SUB;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause = cause_q;
  assign dbg_state  = state_q;

`ifdef MCFSM_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign cycle_cnt     = '0;
  assign instret_cnt   = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed cases plus random instruction streams
// scored cycle-by-cycle against a per-instruction step model.
module tb_multicycle_ctrl_fsm;

  localparam int TO    = 4;
  localparam int CNT_W = 32;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [6:0]       opcode = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic             reg_write, mem_to_reg, trap;
  logic [1:0]       alu_src_a, alu_src_b, alu_op, trap_cause;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  logic [3:0]       dbg_state;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .trap(trap), .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // One expected cycle: inputs to drive, outputs expected, and whether the
  // edge closing this cycle retires an instruction.
  typedef struct packed {
    logic        rdy;
    logic        z;
    logic [6:0]  opc;
    logic [16:0] exp;
    logic        ret;
  } step_t;

  step_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int unsigned m_cyc = 0;
  int unsigned m_inst = 0;
  logic [6:0]  cur_opc;
  logic        cur_z;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [16:0] pack(input logic req, input logic we, input logic io,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic rw, input logic m2r, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] op,
                                       input logic tr, input logic [1:0] c);
    return {req, we, io, irw, pcw, pcs, rw, m2r, a, b, op, tr, c};
  endfunction

  function automatic logic [16:0] dut_out();
    return {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
            alu_src_a, alu_src_b, alu_op, trap, trap_cause};
  endfunction

  // Control word expected for each step of an instruction.
  function automatic logic [16:0] o_fetch(input logic r);
    return pack(1, 0, 0, r, r, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 2'b00);
  endfunction
  function automatic logic [16:0] o_mem(input int kind, input logic r);
    if (kind == 0) return o_fetch(r);
    if (kind == 1) return pack(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    return pack(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00);
  endfunction
  localparam logic [16:0] O_DECODE = {8'b0, 2'b10, 2'b10, 2'b00, 1'b0, 2'b00};
  localparam logic [16:0] O_EXEC_R = {8'b0, 2'b01, 2'b00, 2'b10, 1'b0, 2'b00};
  localparam logic [16:0] O_EXEC_I = {8'b0, 2'b01, 2'b10, 2'b00, 1'b0, 2'b00};
  localparam logic [16:0] O_WB_ALU = {8'b00000010, 6'b0, 1'b0, 2'b00};
  localparam logic [16:0] O_WB_MEM = {8'b00000011, 6'b0, 1'b0, 2'b00};

  function automatic logic [16:0] o_branch(input logic z);
    return pack(0, 0, 0, 0, z, 1, 0, 0, 2'b01, 2'b00, 2'b01, 0, 2'b00);
  endfunction
  function automatic logic [16:0] o_trap(input logic [1:0] c);
    return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, c);
  endfunction

  function automatic bit legal(input logic [6:0] o);
    return (o == OP_R) || (o == OP_I) || (o == OP_LD) || (o == OP_SD) || (o == OP_BEQ);
  endfunction

  // driver tasks
  task automatic push(input logic rdy, input logic [16:0] e, input logic ret);
    step_t s;
    s.rdy = rdy; s.z = cur_z; s.opc = cur_opc; s.exp = e; s.ret = ret;
    exp_q.push_back(s);
  endtask

  // mem_ready is random outside memory steps; the controller must ignore it.
  task automatic push_idle_rdy(input logic [16:0] e, input logic ret);
    push(1'($urandom_range(0, 1)), e, ret);
  endtask

  // A memory access with `waits` stalled cycles; TO or more stalls end in a timeout.
  task automatic gen_mem(input int kind, input int waits, input logic ret, output bit trapped);
    int n;
    n = (waits >= TO) ? TO : waits;
    for (int i = 0; i < n; i++) push(1'b0, o_mem(kind, 1'b0), 1'b0);
    trapped = (waits >= TO);
    if (!trapped) push(1'b1, o_mem(kind, 1'b1), ret);
  endtask

  task automatic gen_instr(input logic [6:0] opc, input logic z, input int fw, input int mw,
                           output logic [1:0] cause);
    bit tr;
    cur_opc = opc;
    cur_z   = z;
    cause   = 2'b00;
    gen_mem(0, fw, 1'b0, tr);
    if (tr) begin cause = 2'b10; return; end
    push_idle_rdy(O_DECODE, 1'b0);
    case (opc)
      OP_R: begin push_idle_rdy(O_EXEC_R, 0); push_idle_rdy(O_WB_ALU, 1); end
      OP_I: begin push_idle_rdy(O_EXEC_I, 0); push_idle_rdy(O_WB_ALU, 1); end
      OP_LD: begin
        push_idle_rdy(O_EXEC_I, 0);
        gen_mem(1, mw, 1'b0, tr);
        if (tr) cause = 2'b10;
        else push_idle_rdy(O_WB_MEM, 1);
      end
      OP_SD: begin
        push_idle_rdy(O_EXEC_I, 0);
        gen_mem(2, mw, 1'b1, tr);
        if (tr) cause = 2'b10;
      end
      OP_BEQ: push_idle_rdy(o_branch(z), 1);
      default: cause = 2'b01;
    endcase
  endtask

  task automatic trap_tail(input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      cur_opc = 7'($urandom_range(0, 127));
      cur_z   = 1'($urandom_range(0, 1));
      push_idle_rdy(o_trap(c), 1'b0);
    end
  endtask

  task automatic push_fetch_wait();
    push(1'b0, o_fetch(1'b0), 1'b0);
  endtask

  function automatic logic [63:0] exp_cnt(input int unsigned v);
`ifdef MCFSM_PERF_CNT_EN
    return 64'(CNT_W'(v));
`else
    return 64'(v & 0);
`endif
  endfunction

  // scoreboard: replay expected queue one cycle per entry
  task automatic run_q();
    step_t s;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      @(posedge clk); #1;
      mem_ready = s.rdy;
      zero      = s.z;
      opcode    = s.opc;
      @(negedge clk);
      check("ctrl", 64'(dut_out()), 64'(s.exp));
      check("cycle_cnt", 64'(cycle_cnt), exp_cnt(m_cyc));
      check("instret_cnt", 64'(instret_cnt), exp_cnt(m_inst));
      m_cyc++;
      if (s.ret) m_inst++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset     = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("rst_ctrl", 64'(dut_out()), 64'd0);
    check("rst_cycle", 64'(cycle_cnt), 64'd0);
    check("rst_instret", 64'(instret_cnt), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_cyc = 0;
    m_inst = 0;
    @(negedge clk);
    check("s_reset_ctrl", 64'(dut_out()), 64'd0);
    m_cyc++;
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 15) < 13) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 6));
  endfunction

  logic [1:0] c;
  logic [6:0] op;

  initial begin
    // addi with zero wait, then back in FETCH
    do_reset();
    gen_instr(OP_I, 0, 0, 0, c); push_fetch_wait(); run_q();
    // ld with three stall cycles on the read
    do_reset();
    gen_instr(OP_LD, 0, 0, 3, c); push_fetch_wait(); run_q();
    // beq taken then not taken
    gen_instr(OP_BEQ, 1, 0, 0, c); gen_instr(OP_BEQ, 0, 0, 0, c); push_fetch_wait(); run_q();
    // illegal opcode traps and holds until reset
    do_reset();
    gen_instr(7'b1111111, 0, 0, 0, c); trap_tail(c, 100); run_q();
    do_reset();
    gen_instr(OP_I, 0, 1, 0, c); push_fetch_wait(); run_q();
    // sd timeout, then sd completing on the last allowed cycle
    do_reset();
    gen_instr(OP_SD, 0, 0, 10, c); trap_tail(c, 5); run_q();
    do_reset();
    gen_instr(OP_SD, 0, 0, TO - 1, c); push_fetch_wait(); run_q();
    // ten zero-wait adds
    do_reset();
    for (int i = 0; i < 10; i++) gen_instr(OP_R, 0, 0, 0, c);
    push_fetch_wait(); run_q();
`ifdef MCFSM_PERF_CNT_EN
    check("cyc_after_10_adds", 64'(cycle_cnt), 64'd41);
    check("instret_after_10_adds", 64'(instret_cnt), 64'd10);
`else
    check("cyc_after_10_adds", 64'(cycle_cnt), 64'd0);
    check("instret_after_10_adds", 64'(instret_cnt), 64'd0);
`endif

    // random streams
    for (int ep = 0; ep < 25; ep++) begin
      int n;
      bit stop;
      do_reset();
      n = $urandom_range(1, 12);
      stop = 0;
      for (int k = 0; k < n && !stop; k++) begin
        case ($urandom_range(0, 19))
          0, 1, 2, 3:     op = OP_R;
          4, 5, 6, 7:     op = OP_I;
          8, 9, 10:       op = OP_LD;
          11, 12, 13:     op = OP_SD;
          14, 15, 16, 17: op = OP_BEQ;
          default: begin
            op = 7'($urandom_range(0, 127));
            while (legal(op)) op = 7'($urandom_range(0, 127));
          end
        endcase
        gen_instr(op, 1'($urandom_range(0, 1)), rand_wait(), rand_wait(), c);
        if (c != 2'b00) begin
          trap_tail(c, $urandom_range(2, 6));
          stop = 1;
        end
      end
      run_q();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
